logic_pipe_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit: registers `OP(IN1, IN2)` for an eight-entry opcode set over WIDTH-bit operands. Adds valid/ready flow control with bubble collapsing and an optional running-reduction (accumulate) mode. Sits in the datapath wherever a registered two-input logic function is needed. `OP=1` with `STAGES=1` is a registered OR with a handshake.

---
 rtl/logic_pipe_unit.sv | 124 ++++++++++++
 tb/tb_logic_pipe_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit.sv
// Pipelined two-input bitwise logic unit with valid/ready flow control.
// Define LOGIC_PIPE_UNIT_ACC_EN to build the running-reduction accumulator.
module logic_pipe_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [2:0]       OP,
    input  logic             ACC,
    input  logic             LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT1,
    output logic             OUT_LAST
);

    function automatic logic [WIDTH-1:0] f_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            3'd0:    res = a & b;
            3'd1:    res = a | b;
            3'd2:    res = a ^ b;
            3'd3:    res = ~(a & b);
            3'd4:    res = ~(a | b);
            3'd5:    res = ~(a ^ b);
            3'd6:    res = a;
            default: res = ~a;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_last;
    logic [STAGES:0]   w_ready;
    logic [WIDTH-1:0]  w_result;
    logic              w_accept;

    // A stage is ready if any stage at or after it is empty, or the sink takes.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i <= STAGES; i++) begin
            w_ready[i] = OUT_READY;
            for (int j = i; j < STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_ready[i] = 1'b1;
                end
            end
        end
    end

    assign w_accept = IN_VALID && w_ready[0];

`ifdef LOGIC_PIPE_UNIT_ACC_EN
    logic [WIDTH-1:0] r_acc;
    logic             r_acc_active;

    always_comb begin
        w_result = f_op(OP, IN1, IN2);
        if (ACC) begin
            w_result = r_acc_active ? f_op(OP, r_acc, IN1) : IN1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc        <= '0;
            r_acc_active <= 1'b0;
        end else if (w_accept && ACC) begin
            r_acc        <= w_result;
            r_acc_active <= !LAST;
        end
    end
`else
    logic w_unused_acc;

    assign w_unused_acc = ACC;
    assign w_result     = f_op(OP, IN1, IN2);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= IN_VALID;
                if (IN_VALID) begin
                    r_data[0] <= w_result;
                    r_last[0] <= LAST;
                end
            end
            // Delay stages only load when the upstream stage holds a beat.
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                        r_last[i] <= r_last[i-1];
                    end
                end
            end
        end
    end

    assign IN_READY  = w_ready[0];
    assign OUT_VALID = r_valid[STAGES-1];
    assign OUT1      = r_data[STAGES-1];
    assign OUT_LAST  = r_last[STAGES-1];

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Randomised bench for logic_pipe_unit against a queue-based reference model.
// Accumulate scenarios build only when LOGIC_PIPE_UNIT_ACC_EN is defined.
module tb_logic_pipe_unit;

    localparam int W = 8;
    localparam int S = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] IN1 = '0;
    logic [W-1:0] IN2 = '0;
    logic [2:0]   OP = '0;
    logic         ACC = 1'b0;
    logic         LAST = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] OUT1;
    logic         OUT_LAST;

    always #5 CLK = ~CLK;

    logic_pipe_unit #(.WIDTH(W), .STAGES(S)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN1(IN1), .IN2(IN2), .OP(OP), .ACC(ACC), .LAST(LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT1(OUT1), .OUT_LAST(OUT_LAST)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           c;
    } ent_t;

    ent_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] m_acc = '0;
    logic         m_act = 1'b0;

    logic         s_in, s_out, s_ol, s_rdy;
    logic [W-1:0] s_o1;
    int           s_c;

    logic [W-1:0] sweep_tbl [8] = '{8'h24, 8'hBD, 8'h99, 8'hDB,
                                    8'h42, 8'h66, 8'hA5, 8'h5A};

    function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a;
            default: return ~a;
        endcase
    endfunction

    // Drive one cycle, sample at negedge, record accepted beats in the model.
    task automatic cycle(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op,
                         input logic acc, input logic last,
                         input logic ordy);
        logic [W-1:0] r;
        IN_VALID = v; IN1 = a; IN2 = b; OP = op;
        ACC = acc; LAST = last; OUT_READY = ordy;
        @(negedge CLK);
        s_rdy = IN_READY;
        s_in  = v && IN_READY;
        s_out = OUT_VALID && ordy;
        s_o1  = OUT1;
        s_ol  = OUT_LAST;
        s_c   = cyc;
        if (s_in) begin
            r = ref_op(op, a, b);
`ifdef LOGIC_PIPE_UNIT_ACC_EN
            if (acc) begin
                r = m_act ? ref_op(op, m_acc, a) : a;
                m_acc = r;
                m_act = !last;
            end
`endif
            q.push_back('{d: r, l: last, c: cyc});
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT1 !== '0 || OUT_LAST !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h l=%b required 0 00 0",
                     OUT_VALID, OUT1, OUT_LAST);
        end
        RST = 1'b0;
        cycle(0, '0, '0, 3'd0, 0, 0, 0);
        checks++;
        if (s_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", s_rdy);
        end
    endtask

    task automatic test_opcode_sweep();
        int   n = 0;
        ent_t e;
        for (int i = 0; i < 8 + S + 2; i++) begin
            cycle(i < 8, 8'hA5, 8'h3C, 3'(i), 0, 0, 1);
            if (s_out) begin
                checks++;
                if (q.size() == 0 || n >= 8) begin
                    errors++;
                    $display("FAIL sweep_extra got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== sweep_tbl[n] || s_o1 !== e.d ||
                        s_c - e.c != S) begin
                        errors++;
                        $display("FAIL sweep_op%0d got %h lat %0d required %h lat %0d",
                                 n, s_o1, s_c - e.c, sweep_tbl[n], S);
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL sweep_count got %0d required 8", n);
        end
    endtask

    task automatic test_backpressure();
        int   acc_n = 0;
        ent_t e;
        for (int i = 0; i < 5; i++) begin
            cycle(1, W'($urandom), W'($urandom), 3'($urandom), 0,
                  1'($urandom), 0);
            if (s_in) acc_n++;
        end
        checks++;
        if (acc_n != S || s_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill got %0d beats ready %b required %0d beats ready 0",
                     acc_n, s_rdy, S);
        end
        cycle(1, W'($urandom), W'($urandom), 3'($urandom), 0, 0, 1);
        checks++;
        if (!(s_in && s_out)) begin
            errors++;
            $display("FAIL bp_shift got in=%b out=%b required 1 1", s_in, s_out);
        end
        if (s_out) begin
            e = q.pop_front();
            checks++;
            if (s_o1 !== e.d || s_ol !== e.l) begin
                errors++;
                $display("FAIL bp_shift_data got %h/%b required %h/%b",
                         s_o1, s_ol, e.d, e.l);
            end
        end
        for (int i = 0; i < S + 4; i++) begin
            cycle(0, '0, '0, 3'd0, 0, 0, 1);
            if (s_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_dup got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== e.d || s_ol !== e.l) begin
                        errors++;
                        $display("FAIL bp_order got %h/%b required %h/%b",
                                 s_o1, s_ol, e.d, e.l);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_lost got %0d pending required 0", q.size());
        end
    endtask

`ifdef LOGIC_PIPE_UNIT_ACC_EN
    task automatic test_accumulate();
        logic [W-1:0] ins [5]  = '{8'h01, 8'h04, 8'h10, 8'hFF, 8'h0F};
        logic [W-1:0] exps [5] = '{8'h01, 8'h05, 8'h15, 8'hFF, 8'hF0};
        logic [2:0]   ops [5]  = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        logic         lst [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int           n = 0;
        ent_t         e;
        for (int i = 0; i < 5 + S + 2; i++) begin
            if (i < 5)
                cycle(1, ins[i], W'($urandom), ops[i], 1, lst[i], 1);
            else
                cycle(0, '0, '0, 3'd0, 0, 0, 1);
            if (s_out) begin
                checks++;
                if (q.size() == 0 || n >= 5) begin
                    errors++;
                    $display("FAIL acc_extra got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== exps[n] || s_ol !== lst[n] || s_o1 !== e.d) begin
                        errors++;
                        $display("FAIL acc_beat%0d got %h/%b required %h/%b",
                                 n, s_o1, s_ol, exps[n], lst[n]);
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL acc_count got %0d required 5", n);
        end
    endtask
`else
    task automatic test_acc_ignored();
        int   n = 0;
        ent_t e;
        for (int i = 0; i < S + 3; i++) begin
            if (i == 0)
                cycle(1, 8'h0F, 8'hF0, 3'd1, 1, 1, 1);
            else
                cycle(0, '0, '0, 3'd0, 0, 0, 1);
            if (s_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL noacc_extra got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== 8'hFF || s_ol !== 1'b1 || s_o1 !== e.d) begin
                        errors++;
                        $display("FAIL noacc_or got %h/%b required ff/1", s_o1, s_ol);
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL noacc_count got %0d required 1", n);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        int         n = 0;
        ent_t       e;
        logic [2:0] op;
        cycle(1, 8'h81, 8'h00, 3'd6, 1, 0, 0);
        cycle(1, 8'h81, 8'h00, 3'd6, 1, 0, 0);
        RST = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT1 !== '0) begin
            errors++;
            $display("FAIL midreset got v=%b d=%h required 0 00", OUT_VALID, OUT1);
        end
        q.delete();
        m_act = 1'b0;
        m_acc = '0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc++;
`ifdef LOGIC_PIPE_UNIT_ACC_EN
        op = 3'd7;
`else
        op = 3'd6;
`endif
        for (int i = 0; i < S + 3; i++) begin
            if (i == 0)
                cycle(1, 8'h33, W'($urandom), op, 1, 0, 1);
            else
                cycle(0, '0, '0, 3'd0, 0, 0, 1);
            if (s_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_extra got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== 8'h33 || s_o1 !== e.d) begin
                        errors++;
                        $display("FAIL midreset_fresh got %h required 33", s_o1);
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL midreset_count got %0d required 1", n);
        end
    endtask

    task automatic test_random();
        logic ordy, exp_rdy;
        ent_t e;
        for (int i = 0; i < 400 + S + 4; i++) begin
            ordy = (i >= 400) ? 1'b1 : ($urandom % 3 != 0);
            exp_rdy = (q.size() < S) || ordy;
            cycle((i < 400) && ($urandom % 4 != 0), W'($urandom), W'($urandom),
                  3'($urandom), 1'($urandom), ($urandom % 4 == 0), ordy);
            checks++;
            if (s_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d got %b required %b",
                         s_c, s_rdy, exp_rdy);
            end
            if (s_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got %h required none", s_o1);
                end else begin
                    e = q.pop_front();
                    if (s_o1 !== e.d || s_ol !== e.l) begin
                        errors++;
                        $display("FAIL rnd_data cyc %0d got %h/%b required %h/%b",
                                 s_c, s_o1, s_ol, e.d, e.l);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost got %0d pending required 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_opcode_sweep();
        test_backpressure();
`ifdef LOGIC_PIPE_UNIT_ACC_EN
        test_accumulate();
`else
        test_acc_ignored();
`endif
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
